// File: rtl/muldiv_iter.sv
// Iterative RV32M/RV64M multiply/divide unit for the execute stage.
// Shift-add multiply and restoring divide, one bit per cycle, with a pipeline stall output.
module muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            done,
    output logic            busy,
    output logic            stall
);

    // state | meaning
    // IDLE  | waiting for start
    // RUN   | iterating, one multiplier/quotient bit per cycle
    // DONE  | result just written, done high; a new start is accepted here too

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t state, state_next;

    logic [CW-1:0]     cnt;
    logic [2:0]        op;
    logic              sa, sb;
    logic [XLEN-1:0]   opnd, hi, lo;

    logic              accept, finish;
    logic              a_signed, b_signed, is_div, b_zero, ovf, special;
    logic [XLEN-1:0]   mag_a, mag_b, special_res;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [XLEN-1:0]   hi_step, lo_step, final_res;
    logic [2*XLEN-1:0] prod, prod_signed;

    always_comb begin
        a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        mag_a    = (a_signed && a[XLEN-1]) ? -a : a;
        mag_b    = (b_signed && b[XLEN-1]) ? -b : b;
        is_div   = funct3[2];
        b_zero   = (b == '0);
        ovf      = is_div && !funct3[0] && (a == MIN_INT) && (b == '1);
        special  = is_div && (b_zero || ovf);
        if (b_zero) special_res = funct3[1] ? a : '1;
        else        special_res = funct3[1] ? '0 : a;
    end

    // hi/lo hold accumulator/multiplier for multiply, remainder/quotient for divide
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        div_shift = {hi, lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd};
        if (op[2]) begin
            hi_step = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
            lo_step = {lo[XLEN-2:0], ~div_diff[XLEN]};
        end else begin
            hi_step = mul_sum[XLEN:1];
            lo_step = {mul_sum[0], lo[XLEN-1:1]};
        end
        prod        = {hi_step, lo_step};
        prod_signed = (sa ^ sb) ? -prod : prod;
        case (op)
            3'b000:                 final_res = prod_signed[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod_signed[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_res = (sa ^ sb) ? -lo_step : lo_step;
            default:                final_res = sa ? -hi_step : hi_step;
        endcase
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = special ? S_DONE : S_RUN;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (cnt == '0) begin
                    finish     = 1'b1;
                    state_next = S_DONE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (flush) begin
            state_next = S_IDLE;
            accept     = 1'b0;
            finish     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
            cnt    <= '0;
            op     <= '0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            opnd   <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= (state_next == S_DONE);
            busy <= (state_next == S_RUN);
            if (accept) begin
                op  <= funct3;
                sa  <= a_signed & a[XLEN-1];
                sb  <= b_signed & b[XLEN-1];
                cnt <= CW'(XLEN - 1);
                hi  <= '0;
                if (is_div) begin
                    opnd <= mag_b;
                    lo   <= mag_a;
                end else begin
                    opnd <= mag_a;
                    lo   <= mag_b;
                end
                if (special) result <= special_res;
            end else if (state == S_RUN && !flush) begin
                hi  <= hi_step;
                lo  <= lo_step;
                cnt <= cnt - 1'b1;
                if (finish) result <= final_res;
            end
        end
    end

    assign stall = busy | (start & ~busy);

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter (XLEN=32): directed plan values, randomized ops
// against an arithmetic reference, flush/reset/back-to-back timing.
module tb_muldiv_iter;
    localparam int XLEN = 32;
    localparam int LAT  = XLEN + 1;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [2:0]  funct3;
    logic [31:0] a, b, result;
    logic        done, busy, stall;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    muldiv_iter #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .start(start), .flush(flush), .funct3(funct3),
        .a(a), .b(b), .result(result), .done(done), .busy(busy), .stall(stall)
    );

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, ux, uy;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        case (f)
            3'd0: begin p = ux * uy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin p = ux * uy; return p[63:32]; end
            3'd4: begin if (y == 0) return 32'hFFFFFFFF; p = sx / sy; return p[31:0]; end
            3'd5: begin if (y == 0) return 32'hFFFFFFFF; return x / y; end
            3'd6: begin if (y == 0) return x; p = sx % sy; return p[31:0]; end
            default: begin if (y == 0) return x; return x % y; end
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        if (f[2] && (y == 0)) return 1;
        if ((f == 3'd4 || f == 3'd6) && x == 32'h80000000 && y == 32'hFFFFFFFF) return 1;
        return LAT;
    endfunction

    // Drives start in the current cycle (cycle 0) and follows the op until done.
    task automatic do_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] res, output int lat, output int st_cnt, output logic st_done);
        start = 1'b1; funct3 = f; a = x; b = y;
        lat = -1; res = 32'hx; st_done = 1'bx;
        #1;
        st_cnt = stall ? 1 : 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk); start = 1'b0; #1;
            if (done) begin
                lat = k; res = result; st_done = stall;
                break;
            end
            if (stall) st_cnt++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'd0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", result); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
        reset = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic test_directed();
        logic [2:0]  d_f [13] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd7, 3'd4, 3'd7, 3'd4, 3'd6};
        logic [31:0] d_a [13] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                  32'd100, 32'd100, 32'hFFFFFFFF, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
        logic [31:0] d_b [13] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2,
                                  32'd7, 32'd7, 32'h10, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] d_r [13] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF,
                                  32'd14, 32'd2, 32'hF, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0};
        int          d_l [13] = '{33, 33, 33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1};
        logic [31:0] res;
        int          lat, st_cnt;
        logic        st_done;
        for (int i = 0; i < 13; i++) begin
            do_op(d_f[i], d_a[i], d_b[i], res, lat, st_cnt, st_done);
            n_checks++; if (res !== d_r[i]) begin n_fail++; $display("FAIL directed_result[%0d]: got %h expected %h", i, res, d_r[i]); end
            n_checks++; if (lat != d_l[i]) begin n_fail++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, d_l[i]); end
            n_checks++; if (st_cnt != d_l[i]) begin n_fail++; $display("FAIL directed_stall_cycles[%0d]: got %0d expected %0d", i, st_cnt, d_l[i]); end
            n_checks++; if (st_done !== 1'b0) begin n_fail++; $display("FAIL directed_stall_at_done[%0d]: got %b expected 0", i, st_done); end
            if (i % 3 == 2) begin @(negedge clk); #1; end
        end
    endtask

    task automatic test_random();
        logic [2:0]  f;
        logic [31:0] x, y, res;
        int          lat, st_cnt, sel;
        logic        st_done;
        for (int i = 0; i < 60; i++) begin
            f   = 3'($urandom_range(0, 7));
            x   = $urandom;
            y   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) y = 32'h0;
            else if (sel == 1) begin x = 32'h80000000; y = 32'hFFFFFFFF; end
            else if (sel == 2) begin x = $urandom_range(0, 300); y = $urandom_range(1, 20); end
            else if (sel == 3) y = -($urandom_range(1, 20));
            do_op(f, x, y, res, lat, st_cnt, st_done);
            n_checks++; if (res !== model(f, x, y)) begin n_fail++; $display("FAIL random_result[%0d] f=%0d a=%h b=%h: got %h expected %h", i, f, x, y, res, model(f, x, y)); end
            n_checks++; if (lat != model_lat(f, x, y)) begin n_fail++; $display("FAIL random_latency[%0d] f=%0d: got %0d expected %0d", i, f, lat, model_lat(f, x, y)); end
            repeat ($urandom_range(0, 2)) begin @(negedge clk); #1; end
        end
    endtask

    task automatic test_start_in_run();
        logic [31:0] x, y, res;
        int          lat;
        x = 32'h00012345; y = 32'hFFFF0003;
        start = 1'b1; funct3 = 3'd1; a = x; b = y;
        lat = -1; res = 32'hx;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk); #1;
            if (done) begin lat = k; res = result; break; end
            start = (k == 5);
            if (k == 5) begin funct3 = 3'd5; a = 32'd9; b = 32'd0; end
        end
        start = 1'b0;
        n_checks++; if (res !== model(3'd1, x, y)) begin n_fail++; $display("FAIL start_in_run_result: got %h expected %h", res, model(3'd1, x, y)); end
        n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL start_in_run_latency: got %0d expected %0d", lat, LAT); end
        @(negedge clk); #1;
    endtask

    task automatic test_flush();
        logic [31:0] res, old;
        int          lat, st_cnt;
        logic        st_done, saw_done;
        do_op(3'd0, 32'd3, 32'd5, old, lat, st_cnt, st_done);
        @(negedge clk); #1;
        start = 1'b1; funct3 = 3'd5; a = 32'd1000; b = 32'd3;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk); #1;
            start = 1'b0;
            if (k == 10) flush = 1'b1;
        end
        @(negedge clk); #1;
        flush = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b expected 0", busy); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b expected 0", stall); end
        saw_done = done;
        repeat (40) begin @(negedge clk); #1; saw_done |= done; end
        n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL flush_no_done: got %b expected 0", saw_done); end
        n_checks++; if (result !== old) begin n_fail++; $display("FAIL flush_result_held: got %h expected %h", result, old); end
        start = 1'b1; flush = 1'b1; funct3 = 3'd0; a = 32'd2; b = 32'd2;
        @(negedge clk); #1;
        start = 1'b0; flush = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_flush_busy: got %b expected 0", busy); end
        saw_done = done;
        repeat (40) begin @(negedge clk); #1; saw_done |= done; end
        n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL start_flush_no_done: got %b expected 0", saw_done); end
        n_checks++; if (result !== old) begin n_fail++; $display("FAIL start_flush_result_held: got %h expected %h", result, old); end
        res = result;
    endtask

    task automatic test_reset_mid_run();
        logic saw_done;
        start = 1'b1; funct3 = 3'd0; a = 32'h1234; b = 32'h5678;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk); #1;
            start = 1'b0;
            if (k == 20) reset = 1'b1;
        end
        @(negedge clk); #1;
        reset = 1'b0;
        n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL midreset_result: got %h expected 0", result); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midreset_done: got %b expected 0", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL midreset_stall: got %b expected 0", stall); end
        saw_done = 1'b0;
        repeat (40) begin @(negedge clk); #1; saw_done |= done; end
        n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL midreset_no_done: got %b expected 0", saw_done); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] first, res;
        int          lat, st_cnt;
        logic        st_done, hold_ok;
        do_op(3'd0, 32'h1234, 32'h10, first, lat, st_cnt, st_done);
        n_checks++; if (first !== 32'h12340) begin n_fail++; $display("FAIL b2b_first_result: got %h expected %h", first, 32'h12340); end
        start = 1'b1; funct3 = 3'd5; a = 32'd1000; b = 32'd7;
        lat = -1; res = 32'hx; hold_ok = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk); start = 1'b0; #1;
            if (done) begin lat = k; res = result; break; end
            if (result !== first) hold_ok = 1'b0;
        end
        n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected %0d", lat, LAT); end
        n_checks++; if (res !== 32'd142) begin n_fail++; $display("FAIL b2b_second_result: got %h expected %h", res, 32'd142); end
        n_checks++; if (hold_ok !== 1'b1) begin n_fail++; $display("FAIL b2b_result_held: got %b expected 1", hold_ok); end
        @(negedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_in_run();
        test_flush();
        test_reset_mid_run();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_iter.md
# muldiv_iter

Iterative RV32M/RV64M multiply/divide unit, parametrised in operand width. Sits beside the ALU in the execute stage of the pipelined core. It accepts one M-extension operation per `start`, computes it over XLEN iterations, and holds the pipeline through a stall output that the hazard unit ORs into StallF/StallD/StallE. The result is presented with a one-cycle `done` pulse for the EX/MEM register to capture.

## Interface
- `XLEN`, default 32: operand/result width. Legal values are 32 and 64.
- `clk  in  1`: rising-edge clock.
- `reset  in  1`: synchronous, active-high.
- `start  in  1`: request a new operation. Sampled on the rising edge.
- `flush  in  1`: abort the operation in flight (FlushE from the hazard unit).
- `funct3  in  3`: operation select.
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `a  in  XLEN`: rs1 operand (multiplicand/dividend).
- `b  in  XLEN`: rs2 operand (multiplier/divisor).
- `result  out  XLEN`: registered result. Held until the next completion.
- `done  out  1`: high for exactly one cycle when `result` is updated.
- `busy  out  1`: high while in RUN.
- `stall  out  1`: combinational, equal to `busy | (start & ~busy)`. It is low in the DONE cycle.

## Operation
- States: IDLE, RUN, DONE. A log2(XLEN)-bit iteration counter is used in RUN.
- Acceptance:
  - `start` is accepted in IDLE or DONE, which allows back-to-back operations.
  - `start` while in RUN is ignored.
- On accept, the unit latches:
  - `funct3`;
  - the operand magnitudes;
  - the sign flags `sa`, `sb`. The operand is signed when funct3 is MULH, DIV or REM; for MULHSU `a` only is signed; otherwise the operand is unsigned.
- Multiply: shift-add over |a|·|b| into a 2·XLEN product. One multiplier bit per cycle, XLEN cycles.
  - On the final iteration, the product is negated when `sa^sb`.
  - MUL returns the low half; MULH/MULHSU/MULHU return the high half.
- Divide: restoring division on magnitudes, one quotient bit per cycle, XLEN cycles.
  - The quotient is negated when `sa^sb`.
  - The remainder is negated when `sa`.
- Special divides are decided at accept and skip RUN; they go directly to DONE:
  - Divide by zero: the quotient is all ones and the remainder is `a`. This holds for signed and unsigned forms.
  - Signed overflow (`a` = −2^(XLEN−1), `b` = −1): the quotient is `a` and the remainder is 0.
- Transitions:
  - IDLE/DONE + accepted `start` → RUN, or → DONE for a special divide.
  - RUN, after the final (XLEN-th) iteration edge → DONE. `result` is written on that edge.
  - DONE with no `start` → IDLE.
- `flush` has priority over `start` and over iteration.
  - Effect: next state is IDLE, no `done` pulse, and `result` is unchanged.
  - A `start` in the same cycle as `flush` is dropped.
- `reset` has priority over everything, including mid-RUN.
  - `result`, `done` and `busy` go to 0, the state goes to IDLE, and the counter goes to 0.

## Timing
- Let the accepting edge end cycle 0.
- Normal operation:
  - RUN occupies cycles 1..XLEN.
  - `done` is high in cycle XLEN+1, with `result` valid from that cycle.
  - Latency is 33 cycles for XLEN=32 and 65 cycles for XLEN=64. It does not depend on the data.
- Special divide: `done` is high in cycle 1.
- Back-to-back: `start` in a DONE cycle puts RUN in the next cycle. The previous `result` stays valid throughout the new RUN.
- `stall` is high from cycle 0 through cycle XLEN. The EX stage is therefore frozen until `result` is available.
- `done`, `busy` and `result` are all flop outputs. `stall` is the only combinational output.

## Test plan
Values are for XLEN=32.
1. MUL `a`=7, `b`=0xFFFFFFFD → `result`=0xFFFFFFEB; `done` exactly in cycle 33; `stall` high in cycles 0–32.
2. MULH 0x80000000·0x80000000 → 0x40000000. MULHU 0xFFFFFFFF·0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF·0xFFFFFFFF → 0xFFFFFFFF.
3. Division with signs:
   - DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF.
   - DIVU 100/7 → 14; REMU 100/7 → 2.
   - REMU 0xFFFFFFFF/0x10 → 0xF.
4. Special divides:
   - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
   - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM for the same operands → 0.
   - Each has `done` in cycle 1.
5. Flush and start handling:
   - Flush in cycle 10 of a DIVU → no `done`, `result` keeps its old value, `busy` is 0 in cycle 11.
   - A `start` coincident with `flush` is ignored.
   - A `start` pulsed in cycle 5 of RUN does not alter the in-flight result.
6. Reset and back-to-back:
   - Reset asserted in cycle 20 of a MUL → all outputs are 0 and the state is IDLE next cycle; no `done` appears afterwards.
   - Back-to-back MUL then DIVU, with the second `start` in the DONE cycle → two `done` pulses 33 cycles apart, each with the correct value.
